// File: rtl/dcache_ctrl_p_if.sv
// Bundle of the datapath-side and memory-side signals of the data-cache controller.
// The master modport is the controller's view. The slave modport is the view of the
// surrounding cache array and memory arbiter.
interface dcache_ctrl_p_if #(
    parameter int WORDS  = 2,
    parameter int FRAMES = 16,
    parameter int CNT_W  = 32
) ();
    localparam int BW = (WORDS  > 1) ? $clog2(WORDS)  : 1;
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    // datapath / cache-array side
    logic             dmemREN;
    logic             dmemWEN;
    logic             halt_req;
    logic             dhit;
    logic             dirty;
    // memory side
    logic             dwait;
    logic             dREN;
    logic             dWEN;
    logic [BW-1:0]    beat;
    logic             wb_sel;
    logic             fill_we;
    logic [FW-1:0]    frame_idx;
    logic             frame_inval;
    logic             ctstore;
    logic [CNT_W-1:0] hit_count;
    logic             flushing;
    logic             halt;

    modport master (
        input  dmemREN, dmemWEN, halt_req, dhit, dirty, dwait,
        output dREN, dWEN, beat, wb_sel, fill_we, frame_idx, frame_inval,
               ctstore, hit_count, flushing, halt
    );

    modport slave (
        output dmemREN, dmemWEN, halt_req, dhit, dirty, dwait,
        input  dREN, dWEN, beat, wb_sel, fill_we, frame_idx, frame_inval,
               ctstore, hit_count, flushing, halt
    );
endinterface

// File: rtl/dcache_ctrl_p.sv
// Data-cache control unit.
// It sequences clean-miss fills and dirty-miss write-back followed by a fill.
// It also runs the end-of-program flush walk, the hit-count store and the sticky halt.
// The burst length is WORDS beats; the flush walks FRAMES frames.
module dcache_ctrl_p #(
    parameter int WORDS  = 2,
    parameter int FRAMES = 16,
    parameter int CNT_W  = 32
) (
    input  logic             CLK,
    input  logic             RST,
    dcache_ctrl_p_if.master  bus
);
    localparam int BW = (WORDS  > 1) ? $clog2(WORDS)  : 1;
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB      = 3'd1,
        FILL    = 3'd2,
        FLCHK   = 3'd3,
        FLWB    = 3'd4,
        CTSTORE = 3'd5,
        HALT    = 3'd6
    } state_t;

    state_t           state_q,     state_d;
    logic [BW-1:0]    beat_q,      beat_d;
    logic [FW-1:0]    frame_idx_q, frame_idx_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             replay_q,    replay_d;

    logic dren_s, dwen_s, wb_sel_s, fill_we_s, frame_inval_s, ctstore_s, flushing_s, halt_s;
    logic access_s, miss_s, last_beat_s, last_frame_s;

    assign access_s     = bus.dmemREN | bus.dmemWEN;
    assign miss_s       = access_s & ~bus.dhit;
    assign last_beat_s  = (beat_q == BW'(WORDS - 1));
    assign last_frame_s = (frame_idx_q == FW'(FRAMES - 1));

    // State, counters and replay flag; reset wins over every state, including HALT
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            frame_idx_q <= '0;
            hit_count_q <= '0;
            replay_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            frame_idx_q <= frame_idx_d;
            hit_count_q <= hit_count_d;
            replay_q    <= replay_d;
        end
    end

    // Next-state and output decode.
    // While dwait is high, state, beat and all outputs hold steady.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        frame_idx_d   = frame_idx_q;
        hit_count_d   = hit_count_q;
        replay_d      = replay_q;
        dren_s        = 1'b0;
        dwen_s        = 1'b0;
        wb_sel_s      = 1'b0;
        fill_we_s     = 1'b0;
        frame_inval_s = 1'b0;
        ctstore_s     = 1'b0;
        flushing_s    = 1'b0;
        halt_s        = 1'b0;
        case (state_q)
            IDLE: begin
                // The access replayed after a fill hits but must not be counted again
                replay_d = 1'b0;
                if (access_s && bus.dhit && !replay_q) begin
                    hit_count_d = hit_count_q + CNT_W'(1);
                end else begin
                    hit_count_d = hit_count_q;
                end
                if (miss_s && bus.dirty) begin
                    state_d = WB;
                end else if (miss_s) begin
                    state_d = FILL;
                end else if (bus.halt_req) begin
                    state_d = FLCHK;
                end else begin
                    state_d = IDLE;
                end
            end
            WB: begin
                dwen_s   = 1'b1;
                wb_sel_s = 1'b1;
                if (!bus.dwait && last_beat_s) begin
                    beat_d        = '0;
                    frame_inval_s = 1'b1;
                    state_d       = FILL;
                end else if (!bus.dwait) begin
                    beat_d = beat_q + BW'(1);
                end else begin
                    beat_d = beat_q;
                end
            end
            FILL: begin
                dren_s    = 1'b1;
                fill_we_s = ~bus.dwait;
                if (!bus.dwait && last_beat_s) begin
                    beat_d   = '0;
                    replay_d = 1'b1;
                    state_d  = IDLE;
                end else if (!bus.dwait) begin
                    beat_d = beat_q + BW'(1);
                end else begin
                    beat_d = beat_q;
                end
            end
            FLCHK: begin
                flushing_s = 1'b1;
                if (bus.dirty) begin
                    state_d = FLWB;
                end else if (last_frame_s) begin
                    // Clean frame: invalidate it and move on in the same cycle
                    frame_inval_s = 1'b1;
                    state_d       = CTSTORE;
                end else begin
                    frame_inval_s = 1'b1;
                    frame_idx_d   = frame_idx_q + FW'(1);
                end
            end
            FLWB: begin
                flushing_s = 1'b1;
                dwen_s     = 1'b1;
                wb_sel_s   = 1'b1;
                if (!bus.dwait && last_beat_s) begin
                    beat_d        = '0;
                    frame_inval_s = 1'b1;
                    if (last_frame_s) begin
                        state_d = CTSTORE;
                    end else begin
                        frame_idx_d = frame_idx_q + FW'(1);
                        state_d     = FLCHK;
                    end
                end else if (!bus.dwait) begin
                    beat_d = beat_q + BW'(1);
                end else begin
                    beat_d = beat_q;
                end
            end
            CTSTORE: begin
                dwen_s    = 1'b1;
                ctstore_s = 1'b1;
                if (!bus.dwait) begin
                    frame_idx_d = '0;
                    state_d     = HALT;
                end else begin
                    state_d = CTSTORE;
                end
            end
            HALT: begin
                halt_s  = 1'b1;
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dREN        = dren_s;
    assign bus.dWEN        = dwen_s;
    assign bus.beat        = beat_q;
    assign bus.wb_sel      = wb_sel_s;
    assign bus.fill_we     = fill_we_s;
    assign bus.frame_idx   = frame_idx_q;
    assign bus.frame_inval = frame_inval_s;
    assign bus.ctstore     = ctstore_s;
    assign bus.hit_count   = hit_count_q;
    assign bus.flushing    = flushing_s;
    assign bus.halt        = halt_s;
endmodule

// File: tb/tb_dcache_ctrl_p.sv
// Testbench for dcache_ctrl_p.
// Two instances are used: WORDS=4 and WORDS=2, both with FRAMES=4.
// Each stimulus cycle pushes the hand-computed expected output vector into a queue.
// A monitor on the falling edge pops each entry and compares it with the outputs of the targeted instance.
module tb_dcache_ctrl_p;
    logic clk = 1'b0;
    logic rst4, rst2;
    logic dmemREN, dmemWEN, halt_req, dhit, dirty, dwait;

    always #5 clk = ~clk;

    dcache_ctrl_p_if #(.WORDS(4), .FRAMES(4), .CNT_W(32)) bus4 ();
    dcache_ctrl_p_if #(.WORDS(2), .FRAMES(4), .CNT_W(32)) bus2 ();

    assign bus4.dmemREN = dmemREN;  assign bus2.dmemREN = dmemREN;
    assign bus4.dmemWEN = dmemWEN;  assign bus2.dmemWEN = dmemWEN;
    assign bus4.halt_req = halt_req; assign bus2.halt_req = halt_req;
    assign bus4.dhit = dhit;        assign bus2.dhit = dhit;
    assign bus4.dirty = dirty;      assign bus2.dirty = dirty;
    assign bus4.dwait = dwait;      assign bus2.dwait = dwait;

    dcache_ctrl_p #(.WORDS(4), .FRAMES(4), .CNT_W(32)) dut4 (.CLK(clk), .RST(rst4), .bus(bus4));
    dcache_ctrl_p #(.WORDS(2), .FRAMES(4), .CNT_W(32)) dut2 (.CLK(clk), .RST(rst2), .bus(bus2));

    typedef struct packed {
        logic        dren;
        logic        dwen;
        logic [1:0]  beat;
        logic        wb;
        logic        fwe;
        logic [1:0]  fidx;
        logic        finv;
        logic        cts;
        logic [31:0] hc;
        logic        fl;
        logic        hlt;
    } vec_t;

    typedef struct {
        int    dut;
        string nm;
        vec_t  v;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic dren, input logic dwen, input logic [1:0] beat,
                                input logic wb, input logic fwe, input logic [1:0] fidx,
                                input logic finv, input logic cts, input logic [31:0] hc,
                                input logic fl, input logic hlt);
        vec_t r;
        r.dren = dren; r.dwen = dwen; r.beat = beat; r.wb = wb; r.fwe = fwe; r.fidx = fidx;
        r.finv = finv; r.cts = cts; r.hc = hc; r.fl = fl; r.hlt = hlt;
        return r;
    endfunction

    function automatic vec_t e_idle(input int hc);
        return mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'(hc), 1'b0, 1'b0);
    endfunction
    function automatic vec_t e_fill(input int b, input logic fwe, input int hc);
        return mk(1'b1, 1'b0, 2'(b), 1'b0, fwe, 2'd0, 1'b0, 1'b0, 32'(hc), 1'b0, 1'b0);
    endfunction
    function automatic vec_t e_wb(input int b, input logic finv, input int hc);
        return mk(1'b0, 1'b1, 2'(b), 1'b1, 1'b0, 2'd0, finv, 1'b0, 32'(hc), 1'b0, 1'b0);
    endfunction
    function automatic vec_t e_flchk(input int f, input logic finv, input int hc);
        return mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'(f), finv, 1'b0, 32'(hc), 1'b1, 1'b0);
    endfunction
    function automatic vec_t e_flwb(input int f, input int b, input logic finv, input int hc);
        return mk(1'b0, 1'b1, 2'(b), 1'b1, 1'b0, 2'(f), finv, 1'b0, 32'(hc), 1'b1, 1'b0);
    endfunction
    function automatic vec_t e_cts(input int f, input int hc);
        return mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'(f), 1'b0, 1'b1, 32'(hc), 1'b0, 1'b0);
    endfunction
    function automatic vec_t e_halt(input int hc);
        return mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'(hc), 1'b0, 1'b1);
    endfunction

    function automatic string fmt(input vec_t v);
        return $sformatf("dREN=%b dWEN=%b beat=%0d wb_sel=%b fill_we=%b frame_idx=%0d frame_inval=%b ctstore=%b hit_count=%0d flushing=%b halt=%b",
                         v.dren, v.dwen, v.beat, v.wb, v.fwe, v.fidx, v.finv, v.cts, v.hc, v.fl, v.hlt);
    endfunction

    // One stimulus cycle: drive inputs just after the edge and queue the expected outputs
    task automatic cyc(input int d, input string nm, input logic ren, input logic wen,
                       input logic hreq, input logic hit, input logic drt, input logic dw,
                       input vec_t e);
        exp_t t;
        @(posedge clk);
        #1;
        dmemREN = ren; dmemWEN = wen; halt_req = hreq; dhit = hit; dirty = drt; dwait = dw;
        t.dut = d; t.nm = nm; t.v = e;
        exp_q.push_back(t);
    endtask

    // Monitor: compare the targeted instance against the oldest expected entry
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t t;
            vec_t obs;
            t = exp_q.pop_front();
            if (t.dut == 4) begin
                obs = mk(bus4.dREN, bus4.dWEN, bus4.beat, bus4.wb_sel, bus4.fill_we, bus4.frame_idx,
                         bus4.frame_inval, bus4.ctstore, bus4.hit_count, bus4.flushing, bus4.halt);
            end else begin
                obs = mk(bus2.dREN, bus2.dWEN, {1'b0, bus2.beat}, bus2.wb_sel, bus2.fill_we, bus2.frame_idx,
                         bus2.frame_inval, bus2.ctstore, bus2.hit_count, bus2.flushing, bus2.halt);
            end
            n_chk++;
            if (obs !== t.v) begin
                n_fail++;
                $display("FAIL %s: got {%s} expected {%s}", t.nm, fmt(obs), fmt(t.v));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst4 = 1'b1; rst2 = 1'b1;
        dmemREN = 1'b0; dmemWEN = 1'b0; halt_req = 1'b0; dhit = 1'b0; dirty = 1'b0; dwait = 1'b0;

        // Reset state of both instances
        cyc(4, "reset4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(0));
        cyc(2, "reset2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(0));
        rst4 = 1'b0;

        // WORDS=4: reset in the middle of a fill, at beat 1
        cyc(4, "mid_miss",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(0));
        cyc(4, "mid_fill0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_fill(0, 1'b1, 0));
        cyc(4, "mid_fill1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_fill(1, 1'b1, 0));
        rst4 = 1'b1;
        cyc(4, "mid_rst",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(0));
        rst4 = 1'b0;

        // WORDS=4: two hits, then a dirty miss with two wait cycles per beat
        cyc(4, "d_hit0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e_idle(0));
        cyc(4, "d_hit1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e_idle(1));
        cyc(4, "d_miss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_idle(2));
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(4, $sformatf("d_wb_b%0d_k%0d", b, k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (k < 2),
                    e_wb(b, (b == 3 && k == 2), 2));
            end
        end
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(4, $sformatf("d_fill_b%0d_k%0d", b, k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (k < 2),
                    e_fill(b, (k == 2), 2));
            end
        end
        cyc(4, "d_replay", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e_idle(2));
        cyc(4, "d_after",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(2));
        rst4 = 1'b1;
        rst2 = 1'b0;

        // WORDS=2: three hits (one of them a write), then a clean miss
        cyc(2, "c_hit0",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e_idle(0));
        cyc(2, "c_hit1",   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e_idle(1));
        cyc(2, "c_hit2",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e_idle(2));
        cyc(2, "c_miss",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(3));
        cyc(2, "c_fill0",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_fill(0, 1'b1, 3));
        cyc(2, "c_fill1",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_fill(1, 1'b1, 3));
        cyc(2, "c_replay", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e_idle(3));
        cyc(2, "c_after",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(3));

        // WORDS=2: a miss together with halt_req is serviced before the flush starts
        cyc(2, "h_miss",   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_idle(3));
        cyc(2, "h_fill0",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_fill(0, 1'b1, 3));
        cyc(2, "h_fill1",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_fill(1, 1'b1, 3));
        cyc(2, "h_replay", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, e_idle(3));

        // Flush walk with dirty pattern {0,1,0,1}
        cyc(2, "f_chk0",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_flchk(0, 1'b1, 3));
        cyc(2, "f_chk1",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_flchk(1, 1'b0, 3));
        cyc(2, "f_wb1_0",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_flwb(1, 0, 1'b0, 3));
        cyc(2, "f_wb1_1",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_flwb(1, 1, 1'b1, 3));
        cyc(2, "f_chk2",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_flchk(2, 1'b1, 3));
        cyc(2, "f_chk3",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_flchk(3, 1'b0, 3));
        cyc(2, "f_wb3_0",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_flwb(3, 0, 1'b0, 3));
        cyc(2, "f_wb3_1",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_flwb(3, 1, 1'b1, 3));
        cyc(2, "f_cts_w",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e_cts(3, 3));
        cyc(2, "f_cts",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_cts(3, 3));
        cyc(2, "f_halt",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_halt(3));

        // HALT is sticky and ignores every input until reset
        for (int i = 0; i < 10; i++) begin
            cyc(2, $sformatf("halt_sticky%0d", i), 1'b1, 1'b0, 1'b1, (i % 2 == 0), 1'b0, 1'b0, e_halt(3));
        end
        rst2 = 1'b1;
        cyc(2, "halt_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(0));

        @(posedge clk);
        @(posedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
